// File: rtl/axis_stepper_pkg.sv
// Shared constants for the trigger-gated AXI4-Stream stepper.
// Mode encoding for cfg_mode and the two-state burst controller.
package axis_stepper_pkg;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_BURST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/axis_stepper_burst.sv
// Trigger-gated AXIS pass-through, level or counted-burst mode; zero latency, no data register.
// Backpressure: tready follows m_axis_tready while the gate is open; a stalled word only stalls the counter.
module axis_stepper_burst
  import axis_stepper_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int PEND_WIDTH       = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        trg_flag,
  input  logic                        cfg_mode,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic [CNTR_WIDTH-1:0]       sts_bursts,
  output logic                        sts_dropped,
  output logic                        busy,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  state_t                state;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [PEND_WIDTH-1:0] pending;
  logic                  trg_q;
  logic                  trg_edge;
  logic                  pass;
  logic                  hs;
  logic                  last_word;
  logic                  cfg_nz;

  assign trg_edge  = trg_flag & ~trg_q;
  assign cfg_nz    = (cfg_data != '0);
  // Level mode only gates while idle; once a burst runs, mode is ignored until IDLE.
  assign pass      = (state == RUN) | ((cfg_mode == MODE_LEVEL) & trg_flag);
  assign hs        = s_axis_tvalid & m_axis_tready & pass;
  assign last_word = hs & (cntr == CNTR_WIDTH'(1));

  assign s_axis_tready = m_axis_tready & pass;
  assign m_axis_tvalid = s_axis_tvalid & pass;
  assign m_axis_tdata  = s_axis_tdata;
  assign busy          = (state == RUN);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      cntr        <= '0;
      pending     <= '0;
      trg_q       <= 1'b0;
      sts_bursts  <= '0;
      sts_dropped <= 1'b0;
    end else begin
      trg_q <= trg_flag;
      if (state == IDLE) begin
        if ((cfg_mode == MODE_BURST) && trg_edge && cfg_nz) begin
          cntr  <= cfg_data;
          state <= RUN;
        end
      end else if (last_word) begin
        sts_bursts <= sts_bursts + CNTR_WIDTH'(1);
        // A coincident edge replaces the pending decrement, so the queue depth is unchanged.
        if (((pending != '0) || trg_edge) && cfg_nz) begin
          cntr <= cfg_data;
          if (!trg_edge) pending <= pending - PEND_WIDTH'(1);
        end else begin
          cntr    <= '0;
          pending <= '0;
          state   <= IDLE;
        end
      end else begin
        if (hs) cntr <= cntr - CNTR_WIDTH'(1);
        if (trg_edge) begin
          if (&pending) sts_dropped <= 1'b1;
          else          pending     <= pending + PEND_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stepper_burst.sv
// Bench for axis_stepper_burst: directed vector table, corner sequences and a randomized run
// checked against a trigger-queue reference model (narrow counters to reach wrap and drop cases).
module tb_axis_stepper_burst;

  localparam int DW       = 32;
  localparam int CW       = 4;
  localparam int PW       = 2;
  localparam int PEND_MAX = 3;
  localparam int WRAP     = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          trg_flag;
  logic          cfg_mode;
  logic [CW-1:0] cfg_data;
  logic [CW-1:0] sts_bursts;
  logic          sts_dropped;
  logic          busy;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;

  always #5 aclk = ~aclk;

  axis_stepper_burst #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW),
    .PEND_WIDTH      (PW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .trg_flag     (trg_flag),
    .cfg_mode     (cfg_mode),
    .cfg_data     (cfg_data),
    .sts_bursts   (sts_bursts),
    .sts_dropped  (sts_dropped),
    .busy         (busy),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words left in the active burst plus a count of queued triggers.
  int m_left, m_queue, m_bursts;
  bit m_drop, m_prev;

  int unsigned seq;
  int cyc_n, hs_cnt, first_hs, last_hs, fall_cyc;
  bit prev_busy;

  typedef struct {
    bit            rst, trg, mode;
    logic [CW-1:0] data;
    bit            sv, mr;
    bit            e_rdy, e_vld, e_busy;
    logic [CW-1:0] e_bursts;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic bit rb();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic model_reset();
    m_left = 0; m_queue = 0; m_bursts = 0; m_drop = 0; m_prev = 0;
  endtask

  task automatic clear_meas();
    hs_cnt = 0; first_hs = -1; last_hs = -1; fall_cyc = -1; prev_busy = 0;
  endtask

  task automatic hard_reset();
    areset = 1'b1; trg_flag = 1'b0; cfg_mode = 1'b0; cfg_data = '0;
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; s_axis_tdata = '0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_reset();
    clear_meas();
  endtask

  task automatic cyc(input bit rst, input bit trg, input bit mode, input logic [CW-1:0] data,
                     input bit sv, input bit mr);
    bit pass, hs, rise;
    areset = rst; trg_flag = trg; cfg_mode = mode; cfg_data = data;
    s_axis_tvalid = sv; m_axis_tready = mr; s_axis_tdata = 32'hA500_0000 + seq;
    #1;
    pass = (m_left > 0) || (!mode && trg);
    chk("tready",  s_axis_tready, mr & pass);
    chk("tvalid",  m_axis_tvalid, sv & pass);
    chk("busy",    busy, m_left > 0);
    chk("bursts",  sts_bursts, m_bursts);
    chk("dropped", sts_dropped, m_drop);
    hs = sv & mr & pass;
    if (hs) begin
      chk("tdata", m_axis_tdata, 32'hA500_0000 + seq);
      seq++;
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc_n;
      last_hs = cyc_n;
    end
    if (!busy && prev_busy && fall_cyc < 0) fall_cyc = cyc_n;
    prev_busy = busy;
    @(posedge aclk);
    #1;
    cyc_n++;
    if (rst) model_reset();
    else begin
      rise = trg && !m_prev;
      if (m_left > 0) begin
        if (hs) m_left--;
        if (hs && m_left == 0) begin
          m_bursts = (m_bursts + 1) % WRAP;
          if (rise) m_left = data;
          else if (m_queue > 0) begin
            m_queue--;
            m_left = data;
          end
        end else if (rise) begin
          if (m_queue == PEND_MAX) m_drop = 1;
          else m_queue++;
        end
      end else if (mode && rise && data != 0) begin
        m_left = data;
      end
      m_prev = trg;
    end
  endtask

  task automatic run_idle(input logic [CW-1:0] data, input bit rnd);
    for (int i = 0; i < 200 && fall_cyc < 0; i++)
      cyc(0, 0, 1, data, rnd ? rb() : 1'b1, rnd ? rb() : 1'b1);
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    seq = 0; cyc_n = 0;
    hard_reset();

    // rst trg mode data sv mr | rdy vld busy bursts
    tbl[0]  = '{0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 4'd0};
    tbl[1]  = '{0, 1, 0, 4'd0, 1, 1, 1, 1, 0, 4'd0};
    tbl[2]  = '{0, 1, 0, 4'd0, 1, 1, 1, 1, 0, 4'd0};
    tbl[3]  = '{0, 1, 0, 4'd0, 1, 1, 1, 1, 0, 4'd0};
    tbl[4]  = '{0, 1, 0, 4'd0, 1, 1, 1, 1, 0, 4'd0};
    tbl[5]  = '{0, 1, 0, 4'd0, 1, 1, 1, 1, 0, 4'd0};
    tbl[6]  = '{0, 0, 0, 4'd0, 1, 1, 0, 0, 0, 4'd0};
    tbl[7]  = '{0, 0, 1, 4'd2, 1, 1, 0, 0, 0, 4'd0};
    tbl[8]  = '{0, 1, 1, 4'd2, 1, 1, 0, 0, 0, 4'd0};
    tbl[9]  = '{0, 1, 1, 4'd2, 1, 1, 1, 1, 1, 4'd0};
    tbl[10] = '{0, 1, 1, 4'd2, 0, 1, 1, 0, 1, 4'd0};
    tbl[11] = '{0, 1, 1, 4'd2, 1, 0, 0, 1, 1, 4'd0};
    tbl[12] = '{0, 0, 1, 4'd2, 1, 1, 1, 1, 1, 4'd0};
    tbl[13] = '{0, 0, 1, 4'd2, 1, 1, 0, 0, 0, 4'd1};
    tbl[14] = '{0, 1, 1, 4'd0, 1, 1, 0, 0, 0, 4'd1};
    tbl[15] = '{0, 0, 1, 4'd0, 1, 1, 0, 0, 0, 4'd1};
    tbl[16] = '{0, 1, 1, 4'd1, 1, 1, 0, 0, 0, 4'd1};
    tbl[17] = '{0, 0, 1, 4'd1, 1, 1, 1, 1, 1, 4'd1};
    tbl[18] = '{0, 0, 1, 4'd1, 1, 1, 0, 0, 0, 4'd2};

    for (int i = 0; i < 19; i++) begin
      areset = tbl[i].rst; trg_flag = tbl[i].trg; cfg_mode = tbl[i].mode;
      cfg_data = tbl[i].data; s_axis_tvalid = tbl[i].sv; m_axis_tready = tbl[i].mr;
      s_axis_tdata = 32'h1000 + i;
      #1;
      chk($sformatf("vec%0d_tready", i), s_axis_tready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, tbl[i].e_vld);
      chk($sformatf("vec%0d_busy", i),   busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_bursts", i), sts_bursts, tbl[i].e_bursts);
      chk($sformatf("vec%0d_dropped", i), sts_dropped, 0);
      @(posedge aclk);
      #1;
    end

    // Single 8-word burst under random valid/ready.
    hard_reset();
    cyc(0, 1, 1, 4'd8, rb(), rb());
    run_idle(4'd8, 1);
    chk("single_words", hs_cnt, 8);
    chk("single_bursts", sts_bursts, 1);
    chk("single_busy_fall", fall_cyc, last_hs + 1);

    // Three edges queued inside a stalled first burst -> four back-to-back bursts.
    hard_reset();
    cyc(0, 1, 1, 4'd4, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, i % 2 == 1, 1, 4'd4, 1, 0);
    run_idle(4'd4, 0);
    chk("queued_words", hs_cnt, 16);
    chk("queued_bursts", sts_bursts, 4);
    chk("queued_span", last_hs - first_hs + 1, 16);
    chk("queued_dropped", sts_dropped, 0);
    clear_meas();
    cyc(0, 1, 1, 4'd4, 1, 1);
    run_idle(4'd4, 0);
    chk("queue_drained_words", hs_cnt, 4);
    chk("queue_drained_bursts", sts_bursts, 5);

    // Edge coincident with the last handshake, nothing pending.
    hard_reset();
    cyc(0, 1, 1, 4'd3, 1, 1);
    cyc(0, 0, 1, 4'd3, 1, 1);
    cyc(0, 0, 1, 4'd3, 1, 1);
    cyc(0, 1, 1, 4'd3, 1, 1);
    run_idle(4'd3, 0);
    chk("coinc_words", hs_cnt, 6);
    chk("coinc_bursts", sts_bursts, 2);
    chk("coinc_span", last_hs - first_hs + 1, 6);

    // Five edges during a stalled burst: three queue, the rest are dropped.
    hard_reset();
    cyc(0, 1, 1, 4'd2, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, i % 2 == 1, 1, 4'd2, 1, 0);
    run_idle(4'd2, 0);
    chk("drop_flag", sts_dropped, 1);
    chk("drop_bursts", sts_bursts, 4);
    chk("drop_words", hs_cnt, 8);

    // One word per edge, and the burst counter wrapping.
    hard_reset();
    for (int k = 0; k < 15; k++) begin
      cyc(0, 1, 1, 4'd1, 1, 1);
      cyc(0, 0, 1, 4'd1, 1, 1);
    end
    cyc(0, 0, 1, 4'd1, 1, 1);
    chk("one_word_each", hs_cnt, 15);
    chk("wrap_at_max", sts_bursts, 15);
    cyc(0, 1, 1, 4'd1, 1, 1);
    cyc(0, 0, 1, 4'd1, 1, 1);
    chk("wrap_to_zero", sts_bursts, 0);
    cyc(0, 1, 1, 4'd1, 1, 1);
    cyc(0, 0, 1, 4'd1, 1, 1);
    chk("wrap_to_one", sts_bursts, 1);

    // Reset after three of ten words.
    hard_reset();
    cyc(0, 1, 1, 4'd10, 1, 1);
    repeat (3) cyc(0, 0, 1, 4'd10, 1, 1);
    cyc(1, 0, 1, 4'd10, 1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_bursts", sts_bursts, 0);
    chk("rst_dropped", sts_dropped, 0);
    clear_meas();
    cyc(0, 1, 1, 4'd10, 1, 1);
    run_idle(4'd10, 0);
    chk("rst_new_words", hs_cnt, 10);
    chk("rst_new_bursts", sts_bursts, 1);

    // Randomized run against the model.
    hard_reset();
    begin
      bit trg_r = 0;
      for (int seg = 0; seg < 40; seg++) begin
        bit            mode_r = $urandom_range(0, 3) != 0;
        logic [CW-1:0] data_r = CW'($urandom_range(1, 5));
        for (int c = 0; c < 60; c++) begin
          if ($urandom_range(0, 5) == 0) trg_r = ~trg_r;
          cyc($urandom_range(0, 299) == 0, trg_r, mode_r, data_r, rb(), rb());
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
